// File: rtl/conv_core_seq.sv
`default_nettype none
// ============================================================================
// Module   : conv_core_seq
// Purpose  : Sequencer for one band of a convolution core. For every output
//            position p it streams K weight columns and K image columns into
//            the core's buffers (LOAD), waits for the core to signal
//            completion (RUN), then reports the finished position (NEXT).
//            A watchdog aborts the band if the core never finishes.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            start              - one-cycle band request (accepted in IDLE only)
//            busy/done/err      - band status (err is sticky until next start)
//            w_rd_en/w_addr     - weight memory read port
//            img_rd_en/img_addr - image memory read port
//            weight_buffer_en/weight_en, input_buffer_en/input_en
//                               - core buffer write window / column strobes
//            one_conv_done      - core "convolution finished" level
//            conv_valid/conv_idx- per-position completion pulse and index
// Revision : 1.0 - initial release
// ============================================================================
module conv_core_seq #(
  parameter int N       = 16,
  parameter int S       = 2,
  parameter int K       = 3,
  parameter int OUT_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          w_rd_en,
  output logic [$clog2(K)-1:0]          w_addr,
  output logic                          img_rd_en,
  output logic [$clog2(OUT_W*S+K)-1:0]  img_addr,
  output logic                          weight_buffer_en,
  output logic                          weight_en,
  output logic                          input_buffer_en,
  output logic                          input_en,
  input  logic                          one_conv_done,
  output logic                          conv_valid,
  output logic [$clog2(OUT_W)-1:0]      conv_idx
);

  localparam int WA_W = $clog2(K);
  localparam int IA_W = $clog2(OUT_W*S+K);
  localparam int PW   = $clog2(OUT_W);
  localparam int CW   = $clog2(K+1);
  localparam int TW   = $clog2(TIMEOUT);

  localparam logic [CW-1:0] C_LAST = CW'(K);
  localparam logic [PW-1:0] P_LAST = PW'(OUT_W-1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT-1);

  // N is the data width of the memories feeding the core; this block only
  // sequences them, so N matters solely as a sanity bound.
  if (N < 1 || S < 1 || K < 2 || OUT_W < 2 || TIMEOUT < 2) begin : g_param_check
    $error("conv_core_seq: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    NEXT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     p_q, p_d;
  logic [CW-1:0]     c_q, c_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              ocd_q;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cv_q, cv_d;
  logic [PW-1:0]     cidx_q, cidx_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              buf_q, buf_d;
  logic [WA_W-1:0]   waddr_q, waddr_d;
  logic [IA_W-1:0]   iaddr_q, iaddr_d;
  logic              ocd_rise;

  // Only a fresh 0->1 transition counts: a level left over from the previous
  // position (or raised during LOAD) is already captured in ocd_q on RUN entry.
  assign ocd_rise = one_conv_done & ~ocd_q;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          p_d     = '0;
          c_d     = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (c_q == C_LAST) begin
          c_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      RUN: begin
        if (ocd_rise) begin
          state_d = NEXT;
        end else if (cnt_q == T_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      NEXT: begin
        if (p_q == P_LAST) begin
          state_d = IDLE;
        end else begin
          p_d     = p_q + 1'b1;
          c_d     = '0;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so that, once registered, they
    // line up with the cycle in which the FSM actually sits in that state.
    // Reads lead writes by one cycle to cover the memory read latency.
    buf_d   = (state_d == LOAD);
    rd_d    = (state_d == LOAD) && (c_d != C_LAST);
    wr_d    = (state_d == LOAD) && (c_d != '0);
    waddr_d = rd_d ? WA_W'(c_d) : '0;
    iaddr_d = rd_d ? (IA_W'(p_d) * IA_W'(S) + IA_W'(c_d)) : '0;

    // busy drops in the same cycle done or err appears.
    busy_d  = (state_d == LOAD) || (state_d == RUN) ||
              ((state_d == NEXT) && (p_d != P_LAST));
    cv_d    = (state_d == NEXT);
    done_d  = (state_d == NEXT) && (p_d == P_LAST);
    cidx_d  = (state_d == NEXT) ? p_d : cidx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      ocd_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cv_q    <= 1'b0;
      cidx_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      buf_q   <= 1'b0;
      waddr_q <= '0;
      iaddr_q <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      ocd_q   <= one_conv_done;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cv_q    <= cv_d;
      cidx_q  <= cidx_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      buf_q   <= buf_d;
      waddr_q <= waddr_d;
      iaddr_q <= iaddr_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign w_rd_en          = rd_q;
  assign img_rd_en        = rd_q;
  assign w_addr           = waddr_q;
  assign img_addr         = iaddr_q;
  assign weight_buffer_en = buf_q;
  assign input_buffer_en  = buf_q;
  assign weight_en        = wr_q;
  assign input_en         = wr_q;
  assign conv_valid       = cv_q;
  assign conv_idx         = cidx_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_core_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_core_seq
// Purpose  : Self-checking bench for conv_core_seq (K=3, S=2, OUT_W=4,
//            TIMEOUT=16) with a directed vector table plus band-level sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_core_seq;

  localparam int K     = 3;
  localparam int S     = 2;
  localparam int OUT_W = 4;
  localparam int TO    = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       one_conv_done = 1'b0;
  logic       busy, done, err, w_rd_en, img_rd_en;
  logic       weight_buffer_en, weight_en, input_buffer_en, input_en, conv_valid;
  logic [1:0] w_addr, conv_idx;
  logic [3:0] img_addr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  conv_core_seq #(
    .N(16), .S(S), .K(K), .OUT_W(OUT_W), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .img_rd_en(img_rd_en), .img_addr(img_addr),
    .weight_buffer_en(weight_buffer_en), .weight_en(weight_en),
    .input_buffer_en(input_buffer_en), .input_en(input_en),
    .one_conv_done(one_conv_done), .conv_valid(conv_valid), .conv_idx(conv_idx)
  );

  typedef struct {
    logic       start, ocd;
    logic       busy, rd, wr, bf, cv;
    logic [1:0] wa, ci;
    logic [3:0] ia;
  } vec_t;

  vec_t tbl [0:13];

  function automatic vec_t mk(input logic s, input logic o, input logic b, input logic rd,
                              input logic [1:0] wa, input logic [3:0] ia, input logic wr,
                              input logic bf, input logic cv, input logic [1:0] ci);
    vec_t v;
    v.start = s; v.ocd = o; v.busy = b; v.rd = rd; v.wa = wa; v.ia = ia;
    v.wr = wr; v.bf = bf; v.cv = cv; v.ci = ci;
    return v;
  endfunction

  function automatic logic [31:0] outs();
    return {14'd0, busy, done, err, w_rd_en, img_rd_en, w_addr, img_addr,
            weight_en, input_en, weight_buffer_en, input_buffer_en, conv_valid, conv_idx};
  endfunction

  function automatic logic [31:0] expv(input vec_t v);
    return {14'd0, v.busy, 1'b0, 1'b0, v.rd, v.rd, v.wa, v.ia,
            v.wr, v.wr, v.bf, v.bf, v.cv, v.ci};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Core model: raise one_conv_done rise_at cycles after RUN entry. With hold
  // set the level is left high into the next LOAD and only dropped at RUN+2.
  task automatic run_band(input int rise_at, input bit hold, input bit abort_p2);
    int cyc, load_start, run_idx, np, ndone;
    bit prev_buf, fin;
    cyc = 0; load_start = 0; run_idx = -1000; np = 0; ndone = 0;
    prev_buf = 1'b0; fin = 1'b0;
    one_conv_done = 1'b0;
    start = 1'b1;
    tick();
    for (int k = 0; k < 600; k++) begin
      cyc++;
      start = 1'b0;
      if (weight_buffer_en && !prev_buf) load_start = cyc;
      if (!weight_buffer_en && prev_buf) run_idx = 0;
      else run_idx++;
      prev_buf = weight_buffer_en;

      if (w_rd_en && w_addr == 2'd0)
        chk($sformatf("base_p%0d", np), 32'(img_addr), 2 * np);

      if (abort_p2 && np == 2 && w_rd_en && w_addr == 2'd1) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_zero", outs(), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart", 32'({busy, w_rd_en, img_addr}), 32'({1'b1, 1'b1, 4'd0}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        one_conv_done = 1'b0;
        return;
      end

      if (conv_valid) begin
        chk($sformatf("idx_p%0d", np), 32'(conv_idx), np);
        chk($sformatf("lat_p%0d", np), cyc - load_start, (K + 1) + rise_at + 1);
        np++;
        if (!hold) one_conv_done = 1'b0;
      end

      if (done) begin
        ndone++;
        start = 1'b1;
      end else if (ndone > 0) begin
        chk("start_at_done_ignored", 32'({busy, w_rd_en, weight_buffer_en}), 0);
        fin = 1'b1;
      end

      if (hold && run_idx == 2) one_conv_done = 1'b0;
      if (run_idx == rise_at)   one_conv_done = 1'b1;
      if (np == 1 && run_idx == 3) start = 1'b1;
      if (fin) break;
      tick();
    end
    start = 1'b0;
    one_conv_done = 1'b0;
    chk("band_finished", 32'(fin), 1);
    chk("n_pos", np, OUT_W);
    chk("n_done", ndone, 1);
    chk("err_low", 32'(err), 0);
  endtask

  task automatic run_timeout();
    int run_idx, ndone;
    bit seen, prev_buf;
    run_idx = -1000; ndone = 0; seen = 1'b0; prev_buf = 1'b0;
    one_conv_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (!weight_buffer_en && prev_buf) run_idx = 0;
      else run_idx++;
      prev_buf = weight_buffer_en;
      if (done) ndone++;
      if (err) begin
        seen = 1'b1;
        chk("to_cycles", run_idx, TO);
        chk("to_busy", 32'(busy), 0);
        break;
      end
      tick();
    end
    chk("to_seen", 32'(seen), 1);
    chk("to_done", ndone, 0);
    tick();
    chk("err_sticky", 32'({err, busy}), 32'h2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_cleared", 32'({err, busy}), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    //              s  o  b  rd wa    ia    wr bf cv ci
    tbl[0]  = mk(1, 0, 1, 1, 2'd0, 4'd0, 0, 1, 0, 2'd0);
    tbl[1]  = mk(0, 0, 1, 1, 2'd1, 4'd1, 1, 1, 0, 2'd0);
    tbl[2]  = mk(0, 0, 1, 1, 2'd2, 4'd2, 1, 1, 0, 2'd0);
    tbl[3]  = mk(0, 0, 1, 0, 2'd0, 4'd0, 1, 1, 0, 2'd0);
    tbl[4]  = mk(1, 0, 1, 0, 2'd0, 4'd0, 0, 0, 0, 2'd0);
    tbl[5]  = mk(0, 1, 1, 0, 2'd0, 4'd0, 0, 0, 1, 2'd0);
    tbl[6]  = mk(0, 0, 1, 1, 2'd0, 4'd2, 0, 1, 0, 2'd0);
    tbl[7]  = mk(0, 1, 1, 1, 2'd1, 4'd3, 1, 1, 0, 2'd0);
    tbl[8]  = mk(0, 1, 1, 1, 2'd2, 4'd4, 1, 1, 0, 2'd0);
    tbl[9]  = mk(0, 1, 1, 0, 2'd0, 4'd0, 1, 1, 0, 2'd0);
    tbl[10] = mk(0, 1, 1, 0, 2'd0, 4'd0, 0, 0, 0, 2'd0);
    tbl[11] = mk(0, 1, 1, 0, 2'd0, 4'd0, 0, 0, 0, 2'd0);
    tbl[12] = mk(0, 0, 1, 0, 2'd0, 4'd0, 0, 0, 0, 2'd0);
    tbl[13] = mk(0, 1, 1, 0, 2'd0, 4'd0, 0, 0, 1, 2'd1);

    rst = 1'b1;
    tick();
    tick();
    chk("reset", outs(), 0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      start = tbl[i].start;
      one_conv_done = tbl[i].ocd;
      tick();
      chk($sformatf("vec%0d", i), outs(), expv(tbl[i]));
    end
    start = 1'b0;
    one_conv_done = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    run_band(10, 1'b0, 1'b0);
    run_band(5, 1'b1, 1'b0);
    run_timeout();
    run_band(10, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_core_seq.md
CONV_CORE_SEQ -- requirements
Module: conv_core_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- N, 16, data word width.
- S, 2, stride in image columns.
- K, 3, kernel size.
- OUT_W, 8, output positions per band.
- TIMEOUT, 1024, maximum RUN cycles before error.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle request to process one band.
- busy, out, 1, high from the cycle after an accepted start until the cycle of done or err.
- done, out, 1, one-cycle pulse when the band completes.
- err, out, 1, sticky watchdog flag.
- w_rd_en, out, 1, weight memory read strobe.
- w_addr, out, clog2(K), weight column address.
- img_rd_en, out, 1, image memory read strobe.
- img_addr, out, clog2(OUT_W*S+K), image column address.
- weight_buffer_en, out, 1, conv core weight buffer write window.
- weight_en, out, 1, conv core weight column write strobe.
- input_buffer_en, out, 1, conv core input buffer write window.
- input_en, out, 1, conv core input column write strobe.
- one_conv_done, in, 1, conv core level "convolution finished".
- conv_valid, out, 1, one-cycle pulse when an output position completes.
- conv_idx, out, clog2(OUT_W), index of the completed position.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, LOAD, RUN, NEXT.
REQ-004 In IDLE, start=1 SHALL clear err, set position p=0, and enter LOAD. start SHALL be ignored in every other state.
REQ-005 LOAD SHALL last exactly K+1 cycles, indexed c=0..K, for the current position p:
- w_rd_en=1 and img_rd_en=1 on c=0..K-1, with w_addr=c and img_addr=p*S+c.
- weight_en=1 and input_en=1 on c=1..K; read data arrives one cycle after the read strobe.
- weight_buffer_en=1 and input_buffer_en=1 on c=0..K.
REQ-006 After LOAD the block SHALL enter RUN with both buffer enables low and a cycle counter cleared to 0.
REQ-007 The block SHALL register one_conv_done every cycle. A rising edge (current 1, registered 0) observed in RUN SHALL move the FSM to NEXT. A high level already present on RUN entry, or any level during LOAD, SHALL be ignored.
REQ-008 In RUN the cycle counter SHALL increment once per cycle. If it reaches TIMEOUT-1 without a rising edge, the block SHALL set err=1, deassert busy, return to IDLE, and not pulse done.
REQ-009 NEXT SHALL last one cycle, pulse conv_valid=1 with conv_idx=p, and then:
- if p==OUT_W-1, pulse done=1 in that same cycle and go to IDLE;
- otherwise set p=p+1 and go to LOAD.
REQ-010 Per-position latency from LOAD entry to conv_valid SHALL be (K+1) + (RUN cycles up to and including the detected edge) + 1 cycles.
REQ-011 Read strobes, write strobes and buffer enables SHALL be registered outputs and SHALL be 0 outside LOAD.
REQ-012 img_addr SHALL never exceed (OUT_W-1)*S+K-1; address arithmetic SHALL not wrap.
REQ-013 If start and done coincide in the same cycle, start SHALL be ignored.

Reset
REQ-014 rst=1 SHALL, at the next clock edge, return the FSM to IDLE from any state and set the following to 0: p, the RUN counter, the registered one_conv_done, busy, done, err, conv_valid, conv_idx, all read strobes, all addresses, all write strobes and all buffer enables.
REQ-015 A LOAD interrupted by reset SHALL NOT resume; after reset deasserts, the next start SHALL begin again at p=0, c=0.

Verification
REQ-016 Nominal band (K=3, S=2, OUT_W=4), core model raising one_conv_done 10 cycles after RUN entry -> four conv_valid pulses with conv_idx 0,1,2,3, img_addr base 0,2,4,6, done once, busy low afterward.
REQ-017 LOAD timing check -> strobes high exactly on c=0..2, weight_en/input_en high exactly on c=1..3, buffer enables high for 4 cycles.
REQ-018 one_conv_done held high from the previous position into LOAD and RUN entry -> no NEXT until a fresh 0->1 edge.
REQ-019 one_conv_done never rises, TIMEOUT=16 -> err=1 after 16 RUN cycles, busy=0, done=0; a new start clears err.
REQ-020 rst asserted in the second LOAD cycle of p=2 -> all outputs 0 next cycle; a subsequent start restarts at img_addr=0.
REQ-021 start pulsed while busy, and start in the same cycle as done -> both ignored; exactly one done per accepted start.
